// File: rtl/ysyx_22040237_id_stage.sv
// ysyx_22040237_id_stage: pipelined RV32I/RV64I decode stage with a registered
// decode bundle, valid/ready handshakes, flush and a sticky halt on ebreak.
`default_nettype none

module ysyx_22040237_id_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            flush,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_op1_jump,
  output logic [XLEN-1:0] out_op2_jump,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [3:0]      out_alu_op,
  output logic            out_word,
  output logic            out_rd_w_en,
  output logic [4:0]      out_rd_addr,
  output logic            out_branch,
  output logic [2:0]      out_br_func3,
  output logic            out_jump,
  output logic            out_mem_r,
  output logic            out_mem_w,
  output logic [1:0]      out_mem_size,
  output logic            out_mem_unsigned,
  output logic            out_ebreak,
  output logic            out_invalid,
  output logic            halted,
  output logic [15:0]     invalid_cnt
);

  localparam bit RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;

  typedef struct packed {
    logic [XLEN-1:0] pc, op1, op2, op1j, op2j, rs2d;
    logic [3:0]      alu;
    logic            word, rdw;
    logic [4:0]      rd;
    logic            br;
    logic [2:0]      f3;
    logic            jump, mr, mw;
    logic [1:0]      size;
    logic            uns, ebreak, invalid;
  } bundle_t;

  function automatic logic [3:0] alu_of(input logic [2:0] f, input logic alt);
    case (f)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            legal, rd_en, use_rs1, use_rs2;
  bundle_t         bundle_d, bundle_q;
  logic            valid_d, valid_q, halted_d, halted_q, accept;
  logic [15:0]     cnt_d, cnt_q;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];
  assign rd     = in_inst[11:7];
  assign imm_i  = XLEN'($signed(in_inst[31:20]));
  assign imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

  always_comb begin
    bundle_d    = '0;
    bundle_d.pc = in_pc;
    legal       = 1'b0;
    rd_en       = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_32: begin
        legal = (opcode == OPC_OP) ?
                ((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) :
                (RV64 && (((f7 == 7'h00) && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) ||
                          ((f7 == 7'h20) && (f3 == 3'b000 || f3 == 3'b101))));
        {use_rs1, use_rs2, rd_en} = 3'b111;
        bundle_d.op1  = rs1_data;
        bundle_d.op2  = rs2_data;
        bundle_d.alu  = alu_of(f3, in_inst[30]);
        bundle_d.word = (opcode == OPC_OP_32);
      end
      OPC_OP_IMM: begin
        // RV64 shifts take a 6-bit shamt, so only inst[31:26] must be clean
        case (f3)
          3'b001:  legal = RV64 ? (in_inst[31:26] == 6'h00) : (f7 == 7'h00);
          3'b101:  legal = RV64 ? (in_inst[31:26] == 6'h00 || in_inst[31:26] == 6'h10) :
                                  (f7 == 7'h00 || f7 == 7'h20);
          default: legal = 1'b1;
        endcase
        {use_rs1, rd_en} = 2'b11;
        bundle_d.op1 = rs1_data;
        bundle_d.op2 = imm_i;
        bundle_d.alu = alu_of(f3, (f3 == 3'b101) && in_inst[30]);
      end
      OPC_OP_IMM_32: begin
        legal = RV64 && ((f3 == 3'b000) || (f3 == 3'b001 && f7 == 7'h00) ||
                         (f3 == 3'b101 && (f7 == 7'h00 || f7 == 7'h20)));
        {use_rs1, rd_en} = 2'b11;
        bundle_d.op1  = rs1_data;
        bundle_d.op2  = imm_i;
        bundle_d.alu  = alu_of(f3, (f3 == 3'b101) && in_inst[30]);
        bundle_d.word = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        legal        = 1'b1;
        rd_en        = 1'b1;
        bundle_d.op1 = (opcode == OPC_AUIPC) ? in_pc : '0;
        bundle_d.op2 = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        legal         = (opcode == OPC_JAL) || (f3 == 3'b000);
        rd_en         = 1'b1;
        use_rs1       = (opcode == OPC_JALR);
        bundle_d.op1  = in_pc;
        bundle_d.op2  = XLEN'(4);
        bundle_d.op1j = (opcode == OPC_JAL) ? in_pc : rs1_data;
        bundle_d.op2j = (opcode == OPC_JAL) ? imm_j : imm_i;
        bundle_d.jump = 1'b1;
      end
      OPC_BRANCH: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011);
        {use_rs1, use_rs2} = 2'b11;
        bundle_d.op1  = rs1_data;
        bundle_d.op2  = rs2_data;
        bundle_d.alu  = ALU_SUB;
        bundle_d.op1j = in_pc;
        bundle_d.op2j = imm_b;
        bundle_d.br   = 1'b1;
        bundle_d.f3   = f3;
      end
      OPC_LOAD: begin
        legal = (f3 != 3'b111) && (RV64 || (f3 != 3'b011 && f3 != 3'b110));
        {use_rs1, rd_en} = 2'b11;
        bundle_d.op1  = rs1_data;
        bundle_d.op2  = imm_i;
        bundle_d.mr   = 1'b1;
        bundle_d.size = f3[1:0];
        bundle_d.uns  = f3[2];
      end
      OPC_STORE: begin
        legal = (f3[2] == 1'b0) && (RV64 || f3 != 3'b011);
        {use_rs1, use_rs2} = 2'b11;
        bundle_d.op1  = rs1_data;
        bundle_d.op2  = imm_s;
        bundle_d.rs2d = rs2_data;
        bundle_d.mw   = 1'b1;
        bundle_d.size = f3[1:0];
      end
      OPC_SYSTEM: begin
        legal           = (in_inst == 32'h0010_0073);
        bundle_d.ebreak = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      bundle_d         = '0;
      bundle_d.pc      = in_pc;
      bundle_d.invalid = 1'b1;
      use_rs1          = 1'b0;
      use_rs2          = 1'b0;
    end
    bundle_d.rdw = legal && rd_en && (rd != 5'd0);
    bundle_d.rd  = bundle_d.rdw ? rd : 5'd0;
  end

  assign rs1_addr = use_rs1 ? in_inst[19:15] : 5'd0;
  assign rs2_addr = use_rs2 ? in_inst[24:20] : 5'd0;
  assign in_ready = ~halted_q & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready & ~flush;

  // flush outranks acceptance; a consumed bundle drops only when nothing replaces it
  always_comb begin
    valid_d  = valid_q;
    halted_d = halted_q | (accept & bundle_d.ebreak);
    cnt_d    = cnt_q;
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
    if (accept && bundle_d.invalid && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      halted_q <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
      if (accept) bundle_q <= bundle_d;
    end
  end

  assign out_valid        = valid_q;
  assign out_pc           = bundle_q.pc;
  assign out_op1          = bundle_q.op1;
  assign out_op2          = bundle_q.op2;
  assign out_op1_jump     = bundle_q.op1j;
  assign out_op2_jump     = bundle_q.op2j;
  assign out_rs2_data     = bundle_q.rs2d;
  assign out_alu_op       = bundle_q.alu;
  assign out_word         = bundle_q.word;
  assign out_rd_w_en      = bundle_q.rdw;
  assign out_rd_addr      = bundle_q.rd;
  assign out_branch       = bundle_q.br;
  assign out_br_func3     = bundle_q.f3;
  assign out_jump         = bundle_q.jump;
  assign out_mem_r        = bundle_q.mr;
  assign out_mem_w        = bundle_q.mw;
  assign out_mem_size     = bundle_q.size;
  assign out_mem_unsigned = bundle_q.uns;
  assign out_ebreak       = bundle_q.ebreak;
  assign out_invalid      = bundle_q.invalid;
  assign halted           = halted_q;
  assign invalid_cnt      = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040237_id_stage.sv
// Scoreboard bench for ysyx_22040237_id_stage (XLEN=64 main instance, XLEN=32 side instance).
`default_nettype none

module tb_ysyx_22040237_id_stage;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [63:0] in_pc, rs1_data, rs2_data;
  logic [31:0] in_inst;

  logic        in_ready, out_valid, out_word, out_rd_w_en, out_branch, out_jump, out_mem_r, out_mem_w;
  logic        out_mem_unsigned, out_ebreak, out_invalid, halted;
  logic [4:0]  rs1_addr, rs2_addr, out_rd_addr;
  logic [63:0] out_pc, out_op1, out_op2, out_op1_jump, out_op2_jump, out_rs2_data;
  logic [3:0]  out_alu_op;
  logic [2:0]  out_br_func3;
  logic [1:0]  out_mem_size;
  logic [15:0] invalid_cnt;

  logic        n_in_ready, n_out_valid, n_word, n_rdw, n_br, n_jump, n_mr, n_mw, n_uns, n_eb, n_inv, n_halted;
  logic [4:0]  n_rs1a, n_rs2a, n_rd;
  logic [31:0] n_pc, n_op1, n_op2, n_op1j, n_op2j, n_rs2d;
  logic [3:0]  n_alu;
  logic [2:0]  n_f3;
  logic [1:0]  n_size;
  logic [15:0] n_cnt;

  always #5 clk = ~clk;

  ysyx_22040237_id_stage #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2), .out_op1_jump(out_op1_jump),
    .out_op2_jump(out_op2_jump), .out_rs2_data(out_rs2_data), .out_alu_op(out_alu_op),
    .out_word(out_word), .out_rd_w_en(out_rd_w_en), .out_rd_addr(out_rd_addr),
    .out_branch(out_branch), .out_br_func3(out_br_func3), .out_jump(out_jump),
    .out_mem_r(out_mem_r), .out_mem_w(out_mem_w), .out_mem_size(out_mem_size),
    .out_mem_unsigned(out_mem_unsigned), .out_ebreak(out_ebreak), .out_invalid(out_invalid),
    .halted(halted), .invalid_cnt(invalid_cnt)
  );

  ysyx_22040237_id_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready), .in_pc(in_pc[31:0]),
    .in_inst(in_inst), .flush(flush), .rs1_addr(n_rs1a), .rs2_addr(n_rs2a),
    .rs1_data(rs1_data[31:0]), .rs2_data(rs2_data[31:0]), .out_valid(n_out_valid),
    .out_ready(out_ready), .out_pc(n_pc), .out_op1(n_op1), .out_op2(n_op2),
    .out_op1_jump(n_op1j), .out_op2_jump(n_op2j), .out_rs2_data(n_rs2d), .out_alu_op(n_alu),
    .out_word(n_word), .out_rd_w_en(n_rdw), .out_rd_addr(n_rd), .out_branch(n_br),
    .out_br_func3(n_f3), .out_jump(n_jump), .out_mem_r(n_mr), .out_mem_w(n_mw),
    .out_mem_size(n_size), .out_mem_unsigned(n_uns), .out_ebreak(n_eb), .out_invalid(n_inv),
    .halted(n_halted), .invalid_cnt(n_cnt)
  );

  typedef struct packed {
    logic [63:0] pc, op1, op2, op1j, op2j, rs2d;
    logic [22:0] ctrl;
    logic [4:0]  rs1a, rs2a;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   sb_on = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [22:0] ctl(input logic [3:0] alu, input logic w, rdw, input logic [4:0] rd,
                                      input logic br, input logic [2:0] f3, input logic j, mr, mw,
                                      input logic [1:0] sz, input logic u, eb, inv);
    return {alu, w, rdw, rd, br, f3, j, mr, mw, sz, u, eb, inv};
  endfunction

  function automatic exp_t mk(input logic [63:0] pc, op1, op2, op1j, op2j, rs2d,
                              input logic [22:0] c, input logic [4:0] r1a, r2a);
    exp_t e;
    e = '{pc: pc, op1: op1, op2: op2, op1j: op1j, op2j: op2j, rs2d: rs2d, ctrl: c, rs1a: r1a, rs2a: r2a};
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("out_pc", out_pc, e.pc);
      check("out_op1", out_op1, e.op1);
      check("out_op2", out_op2, e.op2);
      check("out_op1_jump", out_op1_jump, e.op1j);
      check("out_op2_jump", out_op2_jump, e.op2j);
      check("out_rs2_data", out_rs2_data, e.rs2d);
      check("out_ctrl", 64'({out_alu_op, out_word, out_rd_w_en, out_rd_addr, out_branch, out_br_func3,
                             out_jump, out_mem_r, out_mem_w, out_mem_size, out_mem_unsigned,
                             out_ebreak, out_invalid}), 64'(e.ctrl));
    end
  endtask

  // drive one cycle of inputs, then score the transfer and acceptance they cause
  task automatic beat(input logic v, input logic [31:0] inst, input logic [63:0] pc, r1, r2,
                      input logic rdy, fl, input exp_t e);
    @(negedge clk);
    in_valid = v; in_inst = inst; in_pc = pc; rs1_data = r1; rs2_data = r2;
    out_ready = rdy; flush = fl;
    #1;
    if (sb_on && v) begin
      check("rs1_addr", 64'(rs1_addr), 64'(e.rs1a));
      check("rs2_addr", 64'(rs2_addr), 64'(e.rs2a));
    end
    if (sb_on && out_valid && out_ready && !flush) compare_out();
    if (sb_on && in_valid && in_ready && !flush) sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  localparam logic [63:0] P = 64'h8000_0000;
  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    exp_t e_add, e_addi, e_addiw;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_invalid_cnt", 64'(invalid_cnt), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    e_addi = mk(P, 0, 5, 0, 0, 0, ctl(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
    beat(1, 32'h00500093, P, 0, 0, 1, 0, e_addi);
    beat(1, 32'hFE208CE3, P + 4, 7, 7, 1, 0,
         mk(P + 4, 7, 7, P + 4, 64'hFFFF_FFFF_FFFF_FFF8, 0, ctl(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1, 2));
    beat(1, 32'h00113423, P + 8, 64'h1000, 64'hDEAD_BEEF, 1, 0,
         mk(P + 8, 64'h1000, 8, 0, 0, 64'hDEAD_BEEF, ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0), 2, 1));

    // sd held under backpressure while add waits
    e_add = mk(P + 12, 5, 6, 0, 0, 0, ctl(0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 2);
    for (int i = 0; i < 3; i++) begin
      beat(1, 32'h002081B3, P + 12, 5, 6, 0, 0, e_add);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_mem_w", 64'(out_mem_w), 64'd1);
      check("stall_mem_size", 64'(out_mem_size), 64'd3);
      check("stall_op2", out_op2, 64'd8);
    end
    beat(1, 32'h002081B3, P + 12, 5, 6, 1, 0, e_add);
    check("release_in_ready", 64'(in_ready), 64'd1);

    beat(1, 32'h40208233, P + 16, 10, 3, 1, 0,
         mk(P + 16, 10, 3, 0, 0, 0, ctl(1, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 2));
    beat(1, 32'h4210D293, P + 20, 64'h8000_0000_0000_0000, 0, 1, 0,
         mk(P + 20, 64'h8000_0000_0000_0000, 64'h421, 0, 0, 0, ctl(7, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0));
    beat(1, 32'h80000337, P + 24, 64'h55, 0, 1, 0,
         mk(P + 24, 0, 64'hFFFF_FFFF_8000_0000, 0, 0, 0, ctl(0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0));
    beat(1, 32'h00001397, P + 28, 0, 0, 1, 0,
         mk(P + 28, P + 28, 64'h1000, 0, 0, 0, ctl(0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0));
    beat(1, 32'h010000EF, P + 32, 0, 0, 1, 0,
         mk(P + 32, P + 32, 4, P + 32, 16, 0, ctl(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0, 0));
    beat(1, 32'h00008067, P + 36, 64'h8000_1000, 0, 1, 0,
         mk(P + 36, P + 36, 4, 64'h8000_1000, 0, 0, ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1, 0));
    beat(1, 32'hFFF14403, P + 40, 64'h2000, 0, 1, 0,
         mk(P + 40, 64'h2000, M1, 0, 0, 0, ctl(0, 0, 1, 8, 0, 0, 0, 1, 0, 0, 1, 0, 0), 2, 0));
    e_addiw = mk(P + 44, 64'h7FFF_FFFF, M1, 0, 0, 0, ctl(0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0);
    beat(1, 32'hFFF0849B, P + 44, 64'h7FFF_FFFF, 0, 1, 0, e_addiw);
    beat(1, 32'h00000000, P + 48, 0, 0, 1, 0,
         mk(P + 48, 0, 0, 0, 0, 0, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0, 0));

    // flush kills the held addiw and drops the beat presented alongside
    beat(1, 32'hFFF0849B, P + 52, 64'h7FFF_FFFF, 0, 1, 0,
         mk(P + 52, 64'h7FFF_FFFF, M1, 0, 0, 0, ctl(0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0));
    beat(1, 32'h80000337, P + 56, 0, 0, 0, 1, '0);
    check("rv32_addiw_invalid", 64'(n_inv), 64'd1);
    check("rv32_addiw_rdw", 64'(n_rdw), 64'd0);
    check("rv64_addiw_valid", 64'(out_invalid), 64'd0);
    if (sb.size() > 0) void'(sb.pop_front());
    beat(0, 32'h0, 0, 0, 0, 1, 0, '0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_invalid_cnt", 64'(invalid_cnt), 64'd1);
    check("sb_empty_after_flush", 64'(sb.size()), 64'd0);

    // ebreak goes out, then the stage refuses further beats
    beat(1, 32'h00100073, P + 60, 0, 0, 1, 0,
         mk(P + 60, 0, 0, 0, 0, 0, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0, 0));
    beat(1, 32'h00500093, P + 64, 0, 0, 1, 0, e_addi);
    check("halted_set", 64'(halted), 64'd1);
    check("halted_in_ready", 64'(in_ready), 64'd0);
    beat(1, 32'h00500093, P + 64, 0, 0, 1, 0, e_addi);
    check("halted_out_valid", 64'(out_valid), 64'd0);
    check("halted_in_ready2", 64'(in_ready), 64'd0);
    check("sb_empty_after_halt", 64'(sb.size()), 64'd0);

    // asynchronous reset in the middle of a stall
    do_reset();
    beat(1, 32'h00500093, P, 0, 0, 0, 0, e_addi);
    beat(0, 32'h0, 0, 0, 0, 0, 0, '0);
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_all_zero", 64'(|{out_pc, out_op1, out_op2, out_op1_jump, out_op2_jump, out_rs2_data,
                                  out_alu_op, out_word, out_rd_w_en, out_rd_addr, out_branch,
                                  out_br_func3, out_jump, out_mem_r, out_mem_w, out_mem_size,
                                  out_mem_unsigned, out_ebreak, out_invalid}), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd1);
    check("async_halted", 64'(halted), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back zero words saturate the invalid counter
    sb_on = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'h0; out_ready = 1'b1; flush = 1'b0;
    repeat (1000) @(posedge clk);
    #1 check("invalid_cnt_1000", 64'(invalid_cnt), 64'd1000);
    repeat (69000) @(posedge clk);
    #1 check("invalid_cnt_sat", 64'(invalid_cnt), 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/ysyx_22040237_id_stage.md
# ysyx_22040237_id_stage

Pipelined, parametrised instruction-decode stage for the multi-cycle/pipelined NPC core. It accepts one instruction per cycle from IF over a valid/ready handshake, decodes the RV32I/RV64I base integer subset, reads the register file, and presents a registered decode bundle to EX. The single-cycle decoder supported only addi/auipc/lui/jal/jalr/ebreak; this stage adds full integer decode, backpressure, flush and a sticky halt on ebreak.

## Interface
- XLEN, 64, datapath width: 64 enables OP-IMM-32/OP-32 and LD/LWU/SD; 32 treats them as invalid.
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid / in_ready  in / out  1 / 1  IF→ID handshake; a beat transfers when both are 1.
- in_pc / in_inst  in  XLEN / 32  instruction address and word.
- flush  in  1  EX redirect; kills the held bundle and any beat presented this cycle.
- rs1_addr / rs2_addr  out  5 / 5  combinational register-file read addresses, decoded from in_inst.
- rs1_data / rs2_data  in  XLEN / XLEN  combinational register-file read data.
- out_valid / out_ready  out / in  1 / 1  ID→EX handshake.
- out_pc  out  XLEN  registered PC.
- out_op1 / out_op2  out  XLEN / XLEN  ALU operands.
- out_op1_jump / out_op2_jump  out  XLEN / XLEN  target adder operands.
- out_rs2_data  out  XLEN  store data.
- out_alu_op  out  4  ALU operation: ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9.
- out_word  out  1  32-bit op; EX sign-extends the result.
- out_rd_w_en / out_rd_addr  out  1 / 5  writeback enable and address.
- out_branch / out_br_func3  out  1 / 3  conditional branch and its funct3.
- out_jump  out  1  jal/jalr.
- out_mem_r / out_mem_w / out_mem_size / out_mem_unsigned  out  1 / 1 / 2 / 1  load/store control.
- out_ebreak / out_invalid  out  1 / 1  instruction flags.
- halted  out  1  sticky; set once an ebreak is accepted.
- invalid_cnt  out  16  saturating count of accepted invalid instructions.

## Operation
- Decode is combinational on in_inst; the bundle is captured on acceptance.
- Immediates are sign-extended to XLEN: I, S, B ({imm,1'b0}), U ({imm,12'b0}), J ({imm,1'b0}).
- op1/op2 per class:
  - OP: rs1 and rs2.
  - OP-IMM: rs1 and immI. SUB is only for OP with funct7[5]=1. SRAI/SRLI use funct7[5]. In RV64 the shift amount is inst[25:20]; in RV32, inst[25]=1 is invalid.
  - LUI: 0 and immU. AUIPC: pc and immU.
  - JAL: pc and 4, with jump operands pc and immJ.
  - JALR: pc and 4, with jump operands rs1 and immI.
  - Branch: rs1 and rs2, alu_op SUB, jump operands pc and immB.
  - Load: rs1 and immI. Store: rs1 and immS; out_rs2_data = rs2.
- Unused outputs are 0.
- rd_w_en is 1 for OP, OP-IMM, LUI, AUIPC, JAL, JALR and loads. It is forced to 0 when rd=0, for out_invalid, and for ebreak.
- An instruction is invalid if its opcode/funct3/funct7 pattern is outside the supported set; 32'h0 is invalid. Invalid instructions still pass downstream with out_invalid=1 and no side-effect enables.
- rs1_addr/rs2_addr are inst[19:15]/inst[24:20] when the format reads them, else 0.

## Timing
- in_ready = ~halted & (~out_valid | out_ready). Acceptance is in_valid & in_ready & ~flush.
- On acceptance, the bundle register loads and out_valid=1 at the next edge. Latency is 1 cycle, throughput 1/cycle.
- With out_valid=1 and out_ready=0, all out_* hold stable.
- If out_valid & out_ready and there is no new acceptance, out_valid goes to 0 next edge.
- flush=1: out_valid becomes 0 next edge; any in_valid beat that cycle is dropped (in_ready may read 1; IF treats it as consumed). flush has priority over acceptance and over holding.
- halted is set on the edge that accepts an ebreak. That ebreak bundle still goes out. halted clears only on reset; flush does not clear it.
- invalid_cnt increments on each accepted invalid instruction (not on flushed ones) and saturates at 16'hFFFF.
- Reset (async, any time, including mid-stall): out_valid=0, every out_* =0, halted=0, invalid_cnt=0, so in_ready=1. No partial bundle survives.

## Test plan
- addi x1,x0,5 (32'h00500093), pc=0x80000000, out_ready=1 → next cycle out_valid=1, op1=0, op2=5, alu_op=ADD, rd=1, rd_w_en=1.
- beq x1,x2,-8 (32'hFE208CE3) with rs1_data=rs2_data=7 → alu_op=SUB, branch=1, br_func3=0, op2_jump=0xFFFFFFFFFFFFFFF8, rd_w_en=0.
- Backpressure: out_ready=0 for 3 cycles with sd (32'h00113423) held → in_ready=0, bundle stable (mem_w=1, mem_size=3, op2=8). Releasing out_ready accepts the next beat in the same cycle.
- flush asserted while addiw is held and a new beat is presented → out_valid=0 next cycle and invalid_cnt unchanged. With XLEN=32, addiw gives out_invalid=1.
- ebreak (32'h00100073) followed by more valid beats → ebreak is output, halted=1 and in_ready=0 thereafter. rst_n low mid-stall clears all outputs to 0 asynchronously.
- 70000 consecutive 32'h0 beats → invalid_cnt saturates at 16'hFFFF.
